// File: rtl/mesm6_uart.sv
// UART peripheral for the MESM6 bus: TX byte FIFO, single-byte RX buffer, 4-word register map.
// Ports: clk/reset; bus side i_addr/i_read/i_write/i_data -> o_data/o_done; irq to mmu; uart_rx/uart_tx serial.
// Bus latency one clock (o_done held until request drops); TX writes to a full FIFO are dropped.
module mesm6_uart #(
   parameter int DEFAULT_DIV = 87,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic        clk,
   input  logic        reset,
   output logic        irq,
   input  logic [14:0] i_addr,
   input  logic        i_read,
   input  logic        i_write,
   input  logic [47:0] i_data,
   output logic [47:0] o_data,
   output logic        o_done,
   input  logic        uart_rx,
   output logic        uart_tx
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {B_IDLE, B_ACK} bus_t;
   typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_t;
   typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_t;

   // ---------------- bus FSM ----------------
   bus_t bus_q, bus_d;
   logic [1:0] addr;
   logic       req, wr, rd;
   logic       data_wr, data_rd, stat_rd;

   assign addr    = i_addr[1:0];
   assign req     = (bus_q == B_IDLE) && (i_read || i_write);
   assign wr      = req && i_write;
   assign rd      = req && i_read && !i_write;   // read+write together counts as a write
   assign data_wr = wr && (addr == 2'd0);
   assign data_rd = rd && (addr == 2'd0);
   assign stat_rd = rd && (addr == 2'd1);

   always_ff @(posedge clk or posedge reset)
      if (reset) bus_q <= B_IDLE;
      else       bus_q <= bus_d;

   always_comb begin
      bus_d = bus_q;
      case (bus_q)
         B_IDLE: if (i_read || i_write) bus_d = B_ACK;
         B_ACK:  if (!i_read && !i_write) bus_d = B_IDLE;
         default: bus_d = B_IDLE;
      endcase
   end

   always_comb o_done = (bus_q == B_ACK);

   // ---------------- registers ----------------
   logic [15:0] div_q;
   logic [1:0]  ie_q;
   logic [7:0]  rx_byte;
   logic        rx_valid, overrun, frame_err;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         div_q <= 16'(DEFAULT_DIV);
         ie_q  <= 2'b00;
      end else if (wr) begin
         if (addr == 2'd2) div_q <= (i_data[15:0] < 16'd4) ? 16'd4 : i_data[15:0];
         if (addr == 2'd3) ie_q  <= i_data[1:0];
      end

   // ---------------- TX FIFO ----------------
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [CW-1:0] cnt;
   logic          tx_empty, tx_full, tx_pop, push;

   assign tx_empty = (cnt == '0);
   assign tx_full  = (cnt == CW'(FIFO_DEPTH));
   assign push     = data_wr && (!tx_full || tx_pop);   // pop frees the slot this same cycle

   always_ff @(posedge clk)
      if (push) fifo_mem[wp] <= i_data[7:0];

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push)   wp <= wp + 1'b1;
         if (tx_pop) rp <= rp + 1'b1;
         cnt <= cnt + CW'(push) - CW'(tx_pop);
      end

   // ---------------- TX FSM ----------------
   tx_t         tx_q, tx_d;
   logic [15:0] tx_div, tx_cnt;
   logic [7:0]  tx_sh;
   logic [2:0]  tx_bit;
   logic        tx_tick, tx_busy;

   assign tx_tick = (tx_cnt == tx_div - 16'd1);
   // Pop at idle, or at the end of a stop bit so frames run back to back.
   assign tx_pop  = !tx_empty && ((tx_q == T_IDLE) || ((tx_q == T_STOP) && tx_tick));

   always_ff @(posedge clk or posedge reset)
      if (reset) tx_q <= T_IDLE;
      else       tx_q <= tx_d;

   always_comb begin
      tx_d = tx_q;
      case (tx_q)
         T_IDLE:  if (tx_pop) tx_d = T_START;
         T_START: if (tx_tick) tx_d = T_DATA;
         T_DATA:  if (tx_tick && tx_bit == 3'd7) tx_d = T_STOP;
         T_STOP:  if (tx_tick) tx_d = tx_pop ? T_START : T_IDLE;
         default: tx_d = T_IDLE;
      endcase
   end

   always_comb begin
      tx_busy = (tx_q != T_IDLE);
      uart_tx = 1'b1;
      if (tx_q == T_START)     uart_tx = 1'b0;
      else if (tx_q == T_DATA) uart_tx = tx_sh[0];
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         tx_div <= 16'(DEFAULT_DIV);
         tx_cnt <= '0;
         tx_sh  <= '0;
         tx_bit <= '0;
      end else if (tx_pop) begin
         tx_sh  <= fifo_mem[rp];
         tx_div <= div_q;
         tx_cnt <= '0;
         tx_bit <= '0;
      end else if (tx_q != T_IDLE) begin
         if (tx_tick) begin
            tx_cnt <= '0;
            if (tx_q == T_DATA) begin
               tx_sh  <= tx_sh >> 1;
               tx_bit <= tx_bit + 3'd1;
            end
         end else begin
            tx_cnt <= tx_cnt + 16'd1;
         end
      end

   // ---------------- RX ----------------
   rx_t         rx_q, rx_d;
   logic        rx_s1, rx_s2, rx_prev;
   logic [15:0] rx_div, rx_cnt, rx_target;
   logic [7:0]  rx_sh;
   logic [2:0]  rx_bit;
   logic        rx_tick, rx_done;

   always_ff @(posedge clk or posedge reset)
      if (reset) {rx_s1, rx_s2, rx_prev} <= 3'b111;
      else       {rx_s1, rx_s2, rx_prev} <= {uart_rx, rx_s1, rx_s2};

   // Start bit is checked half a period in; later bits a full period apart.
   assign rx_target = (rx_q == R_START) ? (rx_div >> 1) - 16'd1 : rx_div - 16'd1;
   assign rx_tick   = (rx_cnt == rx_target);

   always_ff @(posedge clk or posedge reset)
      if (reset) rx_q <= R_IDLE;
      else       rx_q <= rx_d;

   always_comb begin
      rx_d = rx_q;
      case (rx_q)
         R_IDLE:  if (rx_prev && !rx_s2) rx_d = R_START;
         R_START: if (rx_tick) rx_d = rx_s2 ? R_IDLE : R_DATA;
         R_DATA:  if (rx_tick && rx_bit == 3'd7) rx_d = R_STOP;
         R_STOP:  if (rx_tick) rx_d = rx_s2 ? R_IDLE : R_WAIT;
         R_WAIT:  if (rx_s2) rx_d = R_IDLE;
         default: rx_d = R_IDLE;
      endcase
   end

   always_comb rx_done = (rx_q == R_STOP) && rx_tick;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         rx_div <= 16'(DEFAULT_DIV);
         rx_cnt <= '0;
         rx_sh  <= '0;
         rx_bit <= '0;
      end else if (rx_q == R_IDLE) begin
         rx_div <= div_q;
         rx_cnt <= '0;
         rx_bit <= '0;
      end else if (rx_q != R_WAIT) begin
         if (rx_tick) begin
            rx_cnt <= '0;
            if (rx_q == R_DATA) begin
               rx_sh  <= {rx_s2, rx_sh[7:1]};
               rx_bit <= rx_bit + 3'd1;
            end
         end else begin
            rx_cnt <= rx_cnt + 16'd1;
         end
      end

   // A DATA read in the completion cycle frees the buffer, so the new byte lands without overrun.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         rx_byte   <= '0;
         rx_valid  <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (stat_rd) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
         end
         if (data_rd) rx_valid <= 1'b0;
         if (rx_done) begin
            if (rx_valid && !data_rd) overrun <= 1'b1;
            else begin
               rx_byte  <= rx_sh;
               rx_valid <= 1'b1;
            end
            if (!rx_s2) frame_err <= 1'b1;
         end
      end

   // ---------------- read data / irq ----------------
   logic [47:0] rd_mux;
   always_comb begin
      rd_mux = '0;
      case (addr)
         2'd0: rd_mux = rx_valid ? {40'd0, rx_byte} : 48'd0;
         2'd1: rd_mux = {32'd0, 8'(cnt), 2'b00, frame_err, overrun, tx_busy, rx_valid, tx_full, tx_empty};
         2'd2: rd_mux = {32'd0, div_q};
         default: rd_mux = {46'd0, ie_q};
      endcase
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         o_data <= '0;
         irq    <= 1'b0;
      end else begin
         if (req) o_data <= rd ? rd_mux : 48'd0;
         irq <= (ie_q[0] && rx_valid) || (ie_q[1] && tx_empty && !tx_busy);
      end

   logic unused_bits;
   assign unused_bits = ^{i_addr[14:2], i_data[47:16]};
endmodule

// File: tb/tb_mesm6_uart.sv
module tb_mesm6_uart;
   logic        clk = 1'b0;
   logic        reset;
   logic        irq;
   logic [14:0] i_addr;
   logic        i_read, i_write;
   logic [47:0] i_data, o_data;
   logic        o_done;
   logic        uart_rx, uart_tx;

   always #5 clk = ~clk;

   mesm6_uart dut (
      .clk(clk), .reset(reset), .irq(irq), .i_addr(i_addr), .i_read(i_read),
      .i_write(i_write), .i_data(i_data), .o_data(o_data), .o_done(o_done),
      .uart_rx(uart_rx), .uart_tx(uart_tx)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      bit          chk;
      logic [47:0] val;
      string       name;
   } exp_t;
   exp_t       sb_q[$];
   logic [7:0] tx_q[$];
   int         m_div = 87;
   logic [7:0] m_rx_byte = 8'h00;
   bit         m_rxv = 0, m_ovr = 0, m_ferr = 0;
   bit         mon_en = 1;

   function automatic logic [47:0] idle_status();
      return 48'h1 | (48'(m_rxv) << 2) | (48'(m_ovr) << 4) | (48'(m_ferr) << 5);
   endfunction

   // ---------------- scoreboard monitor for bus reads ----------------
   initial begin
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (o_done && !prev) begin
            if (sb_q.size() == 0) begin
               total++; bad++;
               $display("FAIL sb_unexpected o_data=%0h want=no_transaction", o_data);
            end else begin
               e = sb_q.pop_front();
               if (e.chk) check(e.name, o_data, e.val);
            end
         end
         prev = o_done;
      end
   end

   // ---------------- serial TX monitor ----------------
   initial begin
      int d;
      logic [9:0] fr;
      logic [7:0] eb;
      forever begin
         @(negedge clk);
         if (mon_en && uart_tx === 1'b0) begin
            d = m_div;
            repeat (d / 2) @(negedge clk);
            fr[0] = uart_tx;
            for (int k = 1; k < 10; k++) begin
               repeat (d) @(negedge clk);
               fr[k] = uart_tx;
            end
            if (mon_en) begin
               if (tx_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL tx_extra_frame got=%0h want=none", fr);
               end else begin
                  eb = tx_q.pop_front();
                  check("tx_frame", 48'(fr), 48'({1'b1, eb, 1'b0}));
               end
            end
         end
      end
   end

   // ---------------- bus tasks (entered at posedge+1) ----------------
   task automatic bus(input logic [1:0] a, input bit r, input bit w, input logic [47:0] d,
                      input bit chk, input logic [47:0] expv, input string nm);
      sb_q.push_back('{chk, expv, nm});
      i_addr = {13'd0, a}; i_read = r; i_write = w; i_data = d;
      @(posedge clk); #1;
      check({nm, "_latency"}, 48'(o_done), 48'd1);
      i_read = 1'b0; i_write = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic rd(input logic [1:0] a, input logic [47:0] expv, input string nm);
      bus(a, 1, 0, 48'd0, 1, expv, nm);
   endtask

   task automatic wr(input logic [1:0] a, input logic [47:0] d);
      bus(a, 0, 1, d, 0, 48'd0, "wr");
   endtask

   task automatic wr_div(input int d);
      wr(2'd2, 48'(d));
      m_div = (d < 4) ? 4 : d;
   endtask

   task automatic tx_write(input logic [7:0] b, input bit accepted);
      if (accepted) tx_q.push_back(b);
      wr(2'd0, {40'd0, b});
   endtask

   task automatic rd_status(input string nm);
      rd(2'd1, idle_status(), nm);
      m_ovr = 0; m_ferr = 0;
   endtask

   task automatic rd_data(input string nm);
      rd(2'd0, m_rxv ? {40'd0, m_rx_byte} : 48'd0, nm);
      m_rxv = 0;
   endtask

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rx_frame(input logic [7:0] b, input bit stop_ok);
      logic [9:0] bits;
      bits = {stop_ok, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
         uart_rx = bits[k];
         hold(m_div);
      end
      uart_rx = 1'b1;
      hold(4);
      if (m_rxv) m_ovr = 1;
      else begin
         m_rx_byte = b;
         m_rxv = 1;
      end
      if (!stop_ok) m_ferr = 1;
   endtask

   task automatic drain();
      for (int i = 0; i < 30000 && tx_q.size() != 0; i++) @(posedge clk);
      #1;
      check("tx_drain_left", 48'(tx_q.size()), 48'd0);
      hold(m_div + 2);
   endtask

   // ---------------- waveform capture for the 0x55 frame ----------------
   logic [39:0] cap_vec;
   bit          cap_done = 0;
   bit          cap_seen = 0;

   initial begin
      logic [7:0] b;
      logic [39:0] exp_vec;
      logic [5:0]  od;
      logic [7:0]  r1, r2;
      bit          any_low;

      reset = 1'b1; i_addr = '0; i_read = 0; i_write = 0; i_data = '0; uart_rx = 1'b1;
      hold(3);
      check("rst_irq", 48'(irq), 48'd0);
      check("rst_done", 48'(o_done), 48'd0);
      check("rst_odata", o_data, 48'd0);
      check("rst_uart_tx", 48'(uart_tx), 48'd1);
      reset = 1'b0;
      hold(1);

      rd(2'd2, 48'd87, "div_reset");
      rd(2'd3, 48'd0, "ie_reset");
      rd_status("status_reset");
      wr_div(2);
      rd(2'd2, 48'd4, "div_clamp");

      // exact 4-clock bit timing of 0x55
      wr_div(4);
      fork
         begin
            for (int i = 0; i < 60 && !cap_seen; i++) begin
               @(negedge clk);
               if (uart_tx === 1'b0) cap_seen = 1;
            end
            if (cap_seen) begin
               cap_vec[0] = uart_tx;
               for (int j = 1; j < 40; j++) begin
                  @(negedge clk);
                  cap_vec[j] = uart_tx;
               end
            end
            cap_done = 1;
         end
      join_none
      tx_write(8'h55, 1);
      for (int i = 0; i < 200 && !cap_done; i++) @(posedge clk);
      #1;
      b = 8'h55;
      for (int j = 0; j < 40; j++)
         exp_vec[j] = (j / 4 == 0) ? 1'b0 : (j / 4 == 9) ? 1'b1 : b[j / 4 - 1];
      check("tx55_waveform", cap_seen ? 48'(cap_vec) : 48'hDEAD, 48'(exp_vec));
      drain();
      rd_status("status_after_tx55");

      // FIFO fill: first byte goes to the shifter, 8 fill the FIFO, the 10th is dropped
      wr_div($urandom_range(6, 12));
      for (int i = 0; i < 9; i++) tx_write(8'($urandom), 1);
      rd(2'd1, 48'h080A, "status_fifo_full");
      tx_write(8'($urandom), 0);
      drain();
      rd_status("status_fifo_drained");

      // RX with interrupt
      wr_div(16);
      wr(2'd3, 48'd1);
      rx_frame(8'hA3, 1);
      check("irq_rx_set", 48'(irq), 48'd1);
      rd_data("rx_a3");
      check("irq_rx_clear", 48'(irq), 48'd0);

      // overrun
      r1 = 8'($urandom); r2 = 8'($urandom);
      rx_frame(r1, 1);
      rx_frame(r2, 1);
      rd_status("status_overrun");
      rd_data("rx_keep_first");
      rd_status("status_overrun_cleared");

      // framing error, then a short glitch
      rx_frame(8'($urandom), 0);
      rd_status("status_frame_err");
      rd_data("rx_frame_err_byte");
      uart_rx = 1'b0;
      hold(2);
      uart_rx = 1'b1;
      hold(40);
      rd_status("status_glitch");
      check("irq_glitch", 48'(irq), 48'd0);

      // random TX/RX traffic at random bit periods
      for (int it = 0; it < 5; it++) begin
         wr_div($urandom_range(4, 20));
         tx_write(8'($urandom), 1);
         rx_frame(8'($urandom), 1);
         rd_data("rx_random");
         drain();
      end

      // read held for five cycles consumes the byte once
      rx_frame(8'($urandom), 1);
      sb_q.push_back('{1'b1, {40'd0, m_rx_byte}, "rx_held_read"});
      m_rxv = 0;
      i_addr = 15'd0; i_read = 1'b1;
      od[0] = o_done;
      for (int k = 1; k < 6; k++) begin
         @(posedge clk); #1;
         od[k] = o_done;
      end
      i_read = 1'b0;
      hold(1);
      check("held_read_done", 48'(od), 48'h3E);
      rd_data("rx_consumed_once");

      // read and write together act as a write with zero read data
      bus(2'd3, 1, 1, 48'h3, 1, 48'd0, "rw_odata");
      rd(2'd3, 48'd3, "ie_after_rw");
      check("irq_tx_idle", 48'(irq), 48'd1);
      wr(2'd3, 48'd0);

      // reset in the middle of a TX frame
      wr_div(8);
      mon_en = 0;
      wr(2'd0, 48'h5A);
      wr(2'd0, 48'hC3);
      wr(2'd0, 48'h0F);
      #1 reset = 1'b1;
      #1 check("rst_tx_async", 48'(uart_tx), 48'd1);
      check("rst_done_drop", 48'(o_done), 48'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      m_div = 87; m_rxv = 0; m_ovr = 0; m_ferr = 0;
      hold(1);
      rd_status("status_after_reset");
      rd(2'd2, 48'd87, "div_after_reset");
      any_low = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) any_low = 1;
      end
      check("tx_idle_after_reset", 48'(any_low), 48'd0);

      hold(2);
      check("scoreboard_empty", 48'(sb_q.size()), 48'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mesm6_uart.md
MESM6_UART -- requirements
Module: mesm6_uart

Interface
REQ-001 Parameter DEFAULT_DIV, default 87, reset value of the bit-period register in clocks (115200 baud at 10 MHz).
REQ-002 Parameter FIFO_DEPTH, default 8, TX FIFO depth in bytes, power of two, minimum 2.
REQ-003 clk  input  1  system clock, all state changes on its rising edge.
REQ-004 reset  input  1  reset, asynchronous and active-high.
REQ-005 irq  output  1  level interrupt request to mesm6_mmu.
REQ-006 i_addr  input  15  word address; only i_addr[1:0] is decoded (mmu performs select).
REQ-007 i_read  input  1  read request, held by the initiator until o_done.
REQ-008 i_write  input  1  write request, held by the initiator until o_done.
REQ-009 i_data  input  48  write data.
REQ-010 o_data  output  48  read data, valid while o_done=1.
REQ-011 o_done  output  1  transaction completed.
REQ-012 uart_rx  input  1  serial input, asynchronous, idle high.
REQ-013 uart_tx  output  1  serial output, idle high.

Function
REQ-014 Register map by i_addr[1:0]: 0 DATA, 1 STATUS, 2 DIV, 3 IE.
REQ-015 Bus FSM states IDLE, ACK: IDLE samples read|write, performs the side effect exactly once, moves to ACK; ACK drives o_done=1 and holds it until both i_read and i_write are low, then returns to IDLE.
REQ-016 i_read and i_write both high in IDLE: the cycle is treated as a write; o_data=0.
REQ-017 Latency: o_done rises on the first clock edge after the request is sampled; no wait states.
REQ-018 DATA write: push i_data[7:0] into the TX FIFO; if full, byte dropped, o_done still given.
REQ-019 DATA read: o_data[7:0]=RX byte, [47:8]=0, clears rx_valid; if rx_valid=0, returns 0, no state change.
REQ-020 STATUS read bits: [0] tx_empty, [1] tx_full, [2] rx_valid, [3] tx_busy, [4] overrun, [5] frame_err, [15:8] TX FIFO count, others 0; read clears overrun and frame_err.
REQ-021 DIV write: i_data[15:0] stored; values below 4 stored as 4; read returns stored value zero-extended.
REQ-022 IE: bit0 RX enable, bit1 TX enable; read returns [1:0], rest 0.
REQ-023 irq = (IE[0] & rx_valid) | (IE[1] & tx_empty & ~tx_busy), registered, one cycle after the cause.
REQ-024 Frame format 8N1, LSB first; one bit period = DIV clocks, latched at each frame start (TX and RX independently); mid-frame DIV writes affect only later frames.
REQ-025 TX FSM states IDLE, START, DATA(8), STOP: in IDLE with FIFO non-empty, pop one byte and drive start bit on the next cycle; tx_busy=1 outside IDLE; back-to-back frames without idle gap when FIFO stays non-empty.
REQ-026 Simultaneous push and pop on the same cycle: count unchanged, both take effect; push to a full FIFO on the pop cycle is accepted.
REQ-027 RX: uart_rx passes a 2-flop synchronizer; falling edge in IDLE starts a frame; start bit resampled at DIV/2, low confirms, high aborts to IDLE without flags.
REQ-028 RX samples data bits every DIV clocks from the start-bit midpoint, then the stop bit.
REQ-029 Stop bit low: byte stored anyway, frame_err set; RX waits for line high before next start.
REQ-030 Frame completes with rx_valid=1: new byte discarded, overrun set, old byte kept.
REQ-031 DATA read on the same cycle a frame completes: the read returns the old byte and the new byte is stored with rx_valid=1, no overrun.

Reset
REQ-032 Reset asserted: irq=0, o_done=0, o_data=0, uart_tx=1, FIFO empty, rx_valid=0, flags 0, DIV=DEFAULT_DIV, IE=0, all FSMs IDLE.
REQ-033 Reset mid-frame aborts TX/RX immediately; uart_tx returns high asynchronously; no partial byte retained.
REQ-034 Reset mid-transaction drops o_done; the held request after release is serviced as new.

Verification
REQ-035 Write DIV=4, DATA=0x55 -> uart_tx: start low 4 clk, bits 1,0,1,0,1,0,1,0 each 4 clk, stop high 4 clk; tx_busy=0 after.
REQ-036 Write DATA 9 times with FIFO_DEPTH=8 during first frame -> STATUS count peaks 8 (one in shifter), 9 frames out, or exactly one drop if written before first pop; tx_full observed.
REQ-037 Drive uart_rx frame 0xA3 at DIV=16, IE=1 -> irq=1 after stop sample; DATA read returns 0xA3, irq=0 next cycle.
REQ-038 Two RX frames without read -> STATUS bit4=1, DATA returns first byte; second STATUS read bit4=0.
REQ-039 RX frame with stop bit low -> rx_valid=1, frame_err=1; 2-clk glitch low on uart_rx at DIV=16 -> no byte, no flags.
REQ-040 i_read held 5 cycles -> o_done high from cycle 2 until release, RX byte consumed once; reset pulse mid-TX frame -> uart_tx=1 same cycle, FIFO count 0.
